// File: rtl/bisection_pkg.sv
// Shared types, result codes and helpers for the bisection search controller.
package bisection_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_APPLY,
      ST_WAIT,
      ST_EVAL,
      ST_DONE
   } state_t;

   localparam logic [2:0] STATUS_NONE       = 3'd0;
   localparam logic [2:0] STATUS_CONVERGED  = 3'd1;
   localparam logic [2:0] STATUS_EXHAUSTED  = 3'd2;
   localparam logic [2:0] STATUS_STALLED    = 3'd3;
   localparam logic [2:0] STATUS_ITER_LIMIT = 3'd4;
   localparam logic [2:0] STATUS_BAD_BOUNDS = 3'd5;
   localparam logic [2:0] STATUS_ABORTED    = 3'd6;

   // Widest bus the helper handles; callers zero-extend into it.
   localparam int ABS_W = 32;

   // Magnitude of the difference between two unsigned values.
   function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                 input logic [ABS_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/stall_detector.sv
// Counts consecutive evaluations that produce the same error value.
// The stalled flag is combinational so the controller can act on it in
// the same evaluation cycle that reaches the limit.
module stall_detector #(
   parameter int WIDTH       = 10,
   parameter int STALL_COUNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             evaluate,
   input  logic [WIDTH-1:0] err,
   output logic             stalled
);

   localparam int CNT_W = $clog2(STALL_COUNT + 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic [WIDTH-1:0] prev_err_reg;
   logic             prev_valid_reg;

   // Next run length: grow on a repeated error (saturating), restart at 1 otherwise.
   always_comb begin
      count_next = CNT_W'(1);
      if (prev_valid_reg && (err == prev_err_reg)) begin
         if (count_reg == CNT_W'(STALL_COUNT)) begin
            count_next = count_reg;
         end else begin
            count_next = count_reg + CNT_W'(1);
         end
      end
      stalled = evaluate && (count_next == CNT_W'(STALL_COUNT));
   end

   // Remember the last error and the run length across evaluations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg      <= '0;
         prev_err_reg   <= '0;
         prev_valid_reg <= 1'b0;
      end else if (clear) begin
         count_reg      <= '0;
         prev_err_reg   <= '0;
         prev_valid_reg <= 1'b0;
      end else if (evaluate) begin
         count_reg      <= count_next;
         prev_err_reg   <= err;
         prev_valid_reg <= 1'b1;
      end
   end

endmodule

// File: rtl/bisection_tuner.sv
// Bisection search over i_ref until the measured Q is within TOL of the
// target, with early exit on exhaustion, iteration limit, stall or bad bounds.
module bisection_tuner
   import bisection_pkg::*;
#(
   parameter int BUS_WIDTH   = 10,
   parameter int TOL         = 1,
   parameter int MAX_ITER    = BUS_WIDTH + 2,
   parameter int STALL_COUNT = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              abort,
   input  logic [BUS_WIDTH-1:0]              lo_init,
   input  logic [BUS_WIDTH-1:0]              hi_init,
   input  logic [BUS_WIDTH-1:0]              q_desired,
   input  logic [BUS_WIDTH-1:0]              q_measured,
   input  logic                              meas_valid,
   output logic                              meas_req,
   output logic [BUS_WIDTH-1:0]              i_ref,
   output logic                              busy,
   output logic                              done,
   output logic [2:0]                        status,
   output logic [$clog2(MAX_ITER+1)-1:0]     iter_count
);

   localparam int IW = $clog2(MAX_ITER + 1);

   state_t               state_reg;
   logic [BUS_WIDTH-1:0] lo_reg;
   logic [BUS_WIDTH-1:0] hi_reg;
   logic [BUS_WIDTH-1:0] mid_reg;
   logic [BUS_WIDTH-1:0] q_meas_reg;
   logic [BUS_WIDTH-1:0] best_ref_reg;
   // One bit wider than any error so the first evaluation always becomes best.
   logic [BUS_WIDTH:0]   best_err_reg;

   logic [BUS_WIDTH-1:0] err;
   logic                 is_better;
   logic [BUS_WIDTH:0]   best_err_next;
   logic [BUS_WIDTH-1:0] best_ref_next;
   logic [IW-1:0]        iter_inc;
   logic [BUS_WIDTH-1:0] lo_upd;
   logic [BUS_WIDTH-1:0] hi_upd;
   logic [BUS_WIDTH:0]   mid_sum;
   logic [BUS_WIDTH-1:0] mid_calc;
   logic                 stalled;
   logic                 terminate;
   logic [2:0]           eval_status;

   stall_detector #(
      .WIDTH       (BUS_WIDTH),
      .STALL_COUNT (STALL_COUNT)
   ) u_stall (
      .clk      (clk),
      .rst      (rst),
      .clear    ((state_reg == ST_IDLE) && start),
      .evaluate (state_reg == ST_EVAL),
      .err      (err),
      .stalled  (stalled)
   );

   // Evaluation datapath: error, best point, narrowed interval, next midpoint, exit code.
   always_comb begin
      err           = BUS_WIDTH'(abs_diff(ABS_W'(q_meas_reg), ABS_W'(q_desired)));
      is_better     = {1'b0, err} < best_err_reg;
      best_err_next = is_better ? {1'b0, err} : best_err_reg;
      best_ref_next = is_better ? mid_reg : best_ref_reg;
      iter_inc      = iter_count + IW'(1);

      lo_upd = lo_reg;
      hi_upd = hi_reg;
      if (state_reg == ST_EVAL) begin
         if (q_meas_reg < q_desired) begin
            lo_upd = mid_reg;
         end else begin
            hi_upd = mid_reg;
         end
      end
      // Extra carry bit keeps lo + hi from wrapping.
      mid_sum  = {1'b0, lo_upd} + {1'b0, hi_upd};
      mid_calc = BUS_WIDTH'(mid_sum >> 1);

      terminate   = 1'b1;
      eval_status = STATUS_NONE;
      if (ABS_W'(err) <= ABS_W'(TOL)) begin
         eval_status = STATUS_CONVERGED;
      end else if (stalled) begin
         eval_status = STATUS_STALLED;
      end else if (iter_inc == IW'(MAX_ITER)) begin
         eval_status = STATUS_ITER_LIMIT;
      end else if ((hi_reg - lo_reg) <= BUS_WIDTH'(1)) begin
         eval_status = STATUS_EXHAUSTED;
      end else begin
         terminate = 1'b0;
      end
   end

   // Control FSM with registered outputs; abort overrides any other transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         lo_reg       <= '0;
         hi_reg       <= '1;
         mid_reg      <= '0;
         q_meas_reg   <= '0;
         best_ref_reg <= '0;
         best_err_reg <= '1;
         i_ref        <= '0;
         meas_req     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         status       <= STATUS_NONE;
         iter_count   <= '0;
      end else if (abort && (state_reg != ST_IDLE)) begin
         state_reg <= ST_IDLE;
         meas_req  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         status    <= STATUS_ABORTED;
      end else begin
         meas_req <= 1'b0;
         done     <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  lo_reg       <= lo_init;
                  hi_reg       <= hi_init;
                  iter_count   <= '0;
                  best_err_reg <= '1;
                  status       <= STATUS_NONE;
                  busy         <= 1'b1;
                  state_reg    <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (lo_reg > hi_reg) begin
                  status    <= STATUS_BAD_BOUNDS;
                  done      <= 1'b1;
                  state_reg <= ST_DONE;
               end else begin
                  mid_reg   <= mid_calc;
                  i_ref     <= mid_calc;
                  meas_req  <= 1'b1;
                  state_reg <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               if (meas_valid) begin
                  q_meas_reg <= q_measured;
                  state_reg  <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               iter_count   <= iter_inc;
               best_err_reg <= best_err_next;
               best_ref_reg <= best_ref_next;
               if (terminate) begin
                  status    <= eval_status;
                  i_ref     <= best_ref_next;
                  done      <= 1'b1;
                  state_reg <= ST_DONE;
               end else begin
                  lo_reg    <= lo_upd;
                  hi_reg    <= hi_upd;
                  mid_reg   <= mid_calc;
                  i_ref     <= mid_calc;
                  meas_req  <= 1'b1;
                  state_reg <= ST_APPLY;
               end
            end
            ST_DONE: begin
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
